sqrt_sequencer: RTL

Control stage directly upstream of the `sqrt` datapath. It accepts one radicand per valid/ready transaction and drives the `sqrt` control inputs `load`, `start`, `D`, `excounter` and `ctrl` through the fixed iteration schedule. It captures `Q` and `remainder` when `sqrt` signals `ready`, then presents them downstream on a valid/ready output port. A timeout guards against a `sqrt` core that never completes.

---
 rtl/sqrt_sequencer_pkg.sv | 15 +
 rtl/sqrt_sequencer_iter_down_counter.sv | 32 +++
 rtl/sqrt_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/sqrt_sequencer_pkg.sv
// Shared types and default sizing for the sqrt control stage, its datapath and benches.
package sqrt_pkg;

    localparam int SQRT_DW_DEFAULT      = 16;
    localparam int SQRT_TIMEOUT_DEFAULT = 32;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_ITER = 3'd2,
        ST_WAIT = 3'd3,
        ST_DONE = 3'd4
    } sqrt_state_e;

endpackage

// File: rtl/sqrt_sequencer_iter_down_counter.sv
// Loadable down-counter that walks the iteration index from its preset to zero and holds there.
module iter_down_counter #(
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_load,
    input  logic [CW-1:0] i_load_val,
    input  logic          i_en,
    output logic [CW-1:0] o_count,
    output logic          o_zero
);

    logic [CW-1:0] r_count;

    // Count register: preset wins over decrement, and the count saturates at zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= {CW{1'b0}};
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_en && (r_count != {CW{1'b0}})) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == {CW{1'b0}});

endmodule

// File: rtl/sqrt_sequencer.sv
// Sequences one radicand through the sqrt core's fixed schedule and hands the result downstream.
module sqrt_sequencer
    import sqrt_pkg::*;
#(
    parameter int DW      = SQRT_DW_DEFAULT,
    parameter int TIMEOUT = SQRT_TIMEOUT_DEFAULT
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          load,
    output logic          start,
    output logic          ctrl,
    output logic [DW-1:0] D,
    output logic [DW-1:0] excounter,
    input  logic [DW-1:0] sqrt_Q,
    input  logic [DW-1:0] sqrt_rem,
    input  logic          sqrt_ready,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_root,
    output logic [DW-1:0] out_rem,
    output logic          out_err,
    output logic          busy
);

    localparam int            CW        = $clog2(DW/2 + 1);
    localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] ITER_LOAD = CW'(DW/2);
    localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);

    sqrt_state_e   r_state;
    sqrt_state_e   w_next;
    logic [CW-1:0] w_count;
    logic          w_zero;
    logic [TW-1:0] r_tmo;
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_root;
    logic [DW-1:0] r_rem;
    logic          r_err;
    logic          w_accept;
    logic          w_capture;
    logic          w_tmo_hit;

    assign w_accept  = (r_state == ST_IDLE) && in_valid;
    assign w_capture = (r_state == ST_WAIT) && sqrt_ready;
    assign w_tmo_hit = (r_state == ST_WAIT) && !sqrt_ready && (r_tmo == TMO_LAST);

    iter_down_counter #(.CW(CW)) u_iter_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (r_state == ST_LOAD),
        .i_load_val (ITER_LOAD),
        .i_en       (r_state == ST_ITER),
        .o_count    (w_count),
        .o_zero     (w_zero)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; ITER exits only after the cycle that shows index 0.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (in_valid)                 w_next = ST_LOAD; else w_next = ST_IDLE;
            ST_LOAD:                               w_next = ST_ITER;
            ST_ITER: if (w_zero)                   w_next = ST_WAIT; else w_next = ST_ITER;
            ST_WAIT: if (w_capture || w_tmo_hit)   w_next = ST_DONE; else w_next = ST_WAIT;
            ST_DONE: if (out_ready)                w_next = ST_IDLE; else w_next = ST_DONE;
            default:                               w_next = ST_IDLE;
        endcase
    end

    // Radicand hold, WAIT timeout count and result capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_d    <= {DW{1'b0}};
            r_tmo  <= {TW{1'b0}};
            r_root <= {DW{1'b0}};
            r_rem  <= {DW{1'b0}};
            r_err  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_d <= in_data;
            end else begin
                r_d <= r_d;
            end
            if (r_state == ST_WAIT) begin
                r_tmo <= r_tmo + TW'(1);
            end else begin
                r_tmo <= {TW{1'b0}};
            end
            if (w_capture) begin
                r_root <= sqrt_Q;
                r_rem  <= sqrt_rem;
                r_err  <= 1'b0;
            end else if (w_tmo_hit) begin
                r_root <= {DW{1'b0}};
                r_rem  <= {DW{1'b0}};
                r_err  <= 1'b1;
            end else begin
                r_root <= r_root;
                r_rem  <= r_rem;
                r_err  <= r_err;
            end
        end
    end

    // Control strobes are pure decodes of the state register, so they never glitch on inputs.
    assign in_ready  = (r_state == ST_IDLE);
    assign load      = (r_state == ST_LOAD);
    assign start     = (r_state == ST_LOAD);
    assign ctrl      = (r_state == ST_WAIT);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign excounter = (r_state == ST_ITER) ? {{(DW-CW){1'b0}}, w_count} : {DW{1'b0}};
    assign D         = r_d;
    assign out_root  = r_root;
    assign out_rem   = r_rem;
    assign out_err   = r_err;

endmodule
